// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM states, feature-map geometry
// and the mapping from layer index to the engine's layer-state code.
package layer_sequencer_pkg;

    localparam int FEAT_ELEMS       = 384;
    localparam int DATA_LEN_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CAPT,
        S_DONE,
        S_ERR
    } seq_state_t;

    localparam logic [3:0] LS_IDLE   = 4'h0;
    localparam logic [3:0] LS_AFFINE = 4'hF;

    // Convolution passes use codes 1..14; entry 15 is only reachable as the affine pass.
    localparam logic [3:0] LAYER_CODE [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
        4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, LS_AFFINE, LS_AFFINE
    };

    function automatic logic [3:0] layer_code(input logic [3:0] idx, input logic [3:0] last_idx);
        if (idx == last_idx) begin
            return LS_AFFINE;
        end
        return LAYER_CODE[idx];
    endfunction

endpackage

// File: rtl/layer_sequencer_watchdog.sv
// Per-layer stall watchdog: counts WAIT cycles and flags when TIMEOUT-1 is reached.
module seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == LIMIT);
    assign o_timeout  = w_at_limit;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Initiator-side controller that runs a feature map through NUM_LAYERS engine passes,
// feeding each result back as the next input and flagging stalled layers.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int DATA_LEN   = DATA_LEN_DEFAULT,
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [FEAT_ELEMS*DATA_LEN-1:0] i_d_in,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_err,
    output logic                           o_layer_load,
    output logic [3:0]                     o_cs_layer,
    output logic [FEAT_ELEMS*DATA_LEN-1:0] o_layer_d,
    input  logic                           i_layer_valid,
    input  logic [FEAT_ELEMS*DATA_LEN-1:0] i_layer_q,
    output logic [FEAT_ELEMS*DATA_LEN-1:0] o_q_out
);

    localparam int         FEAT_W   = FEAT_ELEMS * DATA_LEN;
    localparam logic [3:0] LAST_IDX = 4'(NUM_LAYERS - 1);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [3:0]        r_layer_idx;
    logic [FEAT_W-1:0] r_feat;
    logic [FEAT_W-1:0] r_q_out;
    logic              r_err;
    logic              r_valid_q;

    logic w_edge;
    logic w_accept;
    logic w_active;
    logic w_last;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_timeout;

    // A valid level already high on entry to WAIT never produces an edge.
    assign w_edge   = i_layer_valid && !r_valid_q;
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_ERR)) && i_start;
    assign w_active = (r_state == S_LOAD) || (r_state == S_WAIT) || (r_state == S_CAPT);
    assign w_last   = (r_layer_idx == LAST_IDX);

    seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_timeout(w_timeout)
    );

    always_comb begin
        w_next_state = r_state;
        w_wd_clear   = 1'b0;
        w_wd_enable  = 1'b0;
        case (r_state)
            S_IDLE, S_ERR: begin
                if (i_start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_wd_clear   = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (w_edge) begin
                    w_next_state = S_CAPT;
                end else if (w_timeout) begin
                    w_next_state = S_ERR;
                end else begin
                    w_wd_enable = 1'b1;
                end
            end
            S_CAPT: begin
                w_next_state = w_last ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_layer_idx <= '0;
            r_feat      <= '0;
            r_q_out     <= '0;
            r_err       <= 1'b0;
            r_valid_q   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_valid_q <= i_layer_valid;
            if (w_accept) begin
                r_feat      <= i_d_in;
                r_layer_idx <= '0;
                r_err       <= 1'b0;
            end
            if (r_state == S_CAPT) begin
                r_feat <= i_layer_q;
                if (w_last) begin
                    r_q_out <= i_layer_q;
                end else begin
                    r_layer_idx <= r_layer_idx + 1'b1;
                end
            end
            if ((r_state == S_WAIT) && (w_next_state == S_ERR)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_busy       = w_active;
    assign o_done       = (r_state == S_DONE);
    assign o_err        = r_err;
    assign o_layer_load = (r_state == S_LOAD);
    assign o_cs_layer   = w_active ? layer_code(r_layer_idx, LAST_IDX) : LS_IDLE;
    assign o_layer_d    = r_feat;
    assign o_q_out      = r_q_out;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a behavioural engine returning q = d + 1 per element.
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    localparam int DL = 8;
    localparam int NL = 3;
    localparam int TO = 16;
    localparam int FW = FEAT_ELEMS * DL;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [FW-1:0] dIn;
    logic          busy;
    logic          done;
    logic          err;
    logic          layerLoad;
    logic [3:0]    csLayer;
    logic [FW-1:0] layerD;
    logic          layerValid;
    logic [FW-1:0] layerQ;
    logic [FW-1:0] qOut;

    layer_sequencer #(
        .DATA_LEN  (DL),
        .NUM_LAYERS(NL),
        .TIMEOUT   (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_d_in       (dIn),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_layer_load (layerLoad),
        .o_cs_layer   (csLayer),
        .o_layer_d    (layerD),
        .i_layer_valid(layerValid),
        .i_layer_q    (layerQ),
        .o_q_out      (qOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dVal;
        int         delay;
        bit         stuck;
        int         expEnd;
        bit         expErr;
        int         expLoads;
        logic [7:0] expQ;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    int            cycle = 0;
    int            engDelay = 4;
    bit            engStuck = 1'b0;
    int            engCnt = -1;
    logic [FW-1:0] engData;
    logic [3:0]    codes[$];

    function automatic logic [FW-1:0] fillAll(input logic [7:0] v);
        logic [FW-1:0] r;
        for (int i = 0; i < FEAT_ELEMS; i++) r[i*DL +: DL] = v;
        return r;
    endfunction

    function automatic logic [FW-1:0] incAll(input logic [FW-1:0] x);
        logic [FW-1:0] r;
        for (int i = 0; i < FEAT_ELEMS; i++) r[i*DL +: DL] = x[i*DL +: DL] + 8'd1;
        return r;
    endfunction

    // Returns the first element that differs from v, or v when the whole map matches.
    function automatic int firstOdd(input logic [FW-1:0] x, input logic [7:0] v);
        for (int i = 0; i < FEAT_ELEMS; i++) begin
            if (x[i*DL +: DL] !== v) return int'(x[i*DL +: DL]);
        end
        return int'(v);
    endfunction

    function automatic int expCode(input int idx);
        return (idx == NL - 1) ? 15 : idx + 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial forever @(posedge clk) cycle++;

    // Engine model: valid rises engDelay cycles after the load; stuck mode holds the old level into WAIT.
    initial forever begin
        @(negedge clk);
        if (layerLoad) begin
            engCnt  = 0;
            engData = layerD;
            codes.push_back(csLayer);
            if (!engStuck) layerValid = 1'b0;
        end else if (engCnt >= 0) begin
            engCnt++;
            if (engStuck && engCnt == 2) layerValid = 1'b0;
            if (engDelay > 0 && engCnt == engDelay) begin
                layerValid = 1'b1;
                layerQ     = incAll(engData);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] dv, input int dly, input bit stuck,
                                 output int endRel, output bit sawDone, output logic snapBusy,
                                 output logic snapErr, output logic [3:0] snapCs);
        int acc;
        @(negedge clk);
        engDelay = dly;
        engStuck = stuck;
        codes.delete();
        dIn   = fillAll(dv);
        start = 1'b1;
        @(posedge clk);
        #1;
        acc   = cycle - 1;
        start = 1'b0;
        endRel   = -1;
        sawDone  = 1'b0;
        snapBusy = 1'bx;
        snapErr  = 1'bx;
        snapCs   = 4'hx;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done || err) begin
                endRel   = cycle - acc;
                sawDone  = done;
                snapBusy = busy;
                snapErr  = err;
                snapCs   = csLayer;
                break;
            end
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " done"}, int'(done), 0);
        checkOutput({tag, " err"}, int'(err), 0);
        checkOutput({tag, " load"}, int'(layerLoad), 0);
        checkOutput({tag, " cs_layer"}, int'(csLayer), 0);
        checkOutput({tag, " q_out"}, firstOdd(qOut, 8'h00), 0);
        checkOutput({tag, " layer_d"}, firstOdd(layerD, 8'h00), 0);
    endtask

    initial begin
        vec_t       vecs[5];
        int         endRel;
        bit         sawDone;
        logic       sBusy;
        logic       sErr;
        logic [3:0] sCs;
        int         acc;
        int         doneRel;

        vecs[0] = '{8'h05, 4, 1'b0, 19, 1'b0, 3, 8'h08};
        vecs[1] = '{8'h07, 4, 1'b1, 19, 1'b0, 3, 8'h0A};
        vecs[2] = '{8'h01, 16, 1'b0, 55, 1'b0, 3, 8'h04};
        vecs[3] = '{8'h03, -1, 1'b0, 18, 1'b1, 1, 8'h04};
        vecs[4] = '{8'h09, 2, 1'b0, 13, 1'b0, 3, 8'h0C};

        rst        = 1'b1;
        start      = 1'b0;
        dIn        = '0;
        layerValid = 1'b0;
        layerQ     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleZero("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].dVal, vecs[i].delay, vecs[i].stuck, endRel, sawDone, sBusy, sErr, sCs);
            checkOutput($sformatf("row%0d end cycle", i), endRel, vecs[i].expEnd);
            checkOutput($sformatf("row%0d done", i), int'(sawDone), int'(!vecs[i].expErr));
            checkOutput($sformatf("row%0d err", i), int'(sErr), int'(vecs[i].expErr));
            checkOutput($sformatf("row%0d busy", i), int'(sBusy), 0);
            checkOutput($sformatf("row%0d cs_idle", i), int'(sCs), 0);
            checkOutput($sformatf("row%0d loads", i), codes.size(), vecs[i].expLoads);
            for (int j = 0; j < codes.size() && j < NL; j++)
                checkOutput($sformatf("row%0d code%0d", i, j), int'(codes[j]), expCode(j));
            checkOutput($sformatf("row%0d q_out", i), firstOdd(qOut, vecs[i].expQ), int'(vecs[i].expQ));
        end

        // Extra start mid-run must be ignored.
        @(negedge clk);
        engDelay = 4;
        engStuck = 1'b0;
        codes.delete();
        dIn   = fillAll(8'h20);
        start = 1'b1;
        @(posedge clk);
        #1;
        acc   = cycle - 1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        doneRel = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                doneRel = cycle - acc;
                break;
            end
        end
        checkOutput("busy-start done cycle", doneRel, 19);
        checkOutput("busy-start loads", codes.size(), 3);
        checkOutput("busy-start q_out", firstOdd(qOut, 8'h23), 8'h23);

        // Reset in the middle of WAIT.
        @(negedge clk);
        dIn   = fillAll(8'h40);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkIdleZero("mid-rst");
        rst = 1'b0;
        applyStimulus(8'h50, 4, 1'b0, endRel, sawDone, sBusy, sErr, sCs);
        checkOutput("post-rst end cycle", endRel, 19);
        checkOutput("post-rst first code", (codes.size() > 0) ? int'(codes[0]) : -1, expCode(0));
        checkOutput("post-rst q_out", firstOdd(qOut, 8'h53), 8'h53);

        // Back-to-back: start in the IDLE cycle right after done.
        applyStimulus(8'h30, 4, 1'b0, endRel, sawDone, sBusy, sErr, sCs);
        checkOutput("b2b first done", int'(sawDone), 1);
        @(negedge clk);
        dIn   = fillAll(8'h60);
        start = 1'b1;
        @(posedge clk);
        #1;
        acc   = cycle - 1;
        start = 1'b0;
        doneRel = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cycle - acc == 1) checkOutput("b2b busy", int'(busy), 1);
            if (cycle - acc == 18) checkOutput("b2b q_out held", firstOdd(qOut, 8'h33), 8'h33);
            if (done) begin
                doneRel = cycle - acc;
                checkOutput("b2b q_out new", firstOdd(qOut, 8'h63), 8'h63);
                break;
            end
        end
        checkOutput("b2b done cycle", doneRel, 19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
